// File: rtl/psum_serial_reducer_if.sv
// psum_serial_reducer_if: input-vector and result handshakes of the serial psum reducer
interface psum_serial_reducer_if #(
    parameter int col     = 8,
    parameter int bw_psum = 20
);
    logic                     in_valid;
    logic                     in_ready;
    logic [bw_psum*col-1:0]   in_data;
    logic                     relu_en;
    logic                     out_valid;
    logic                     out_ready;
    logic [bw_psum+3:0]       out_sum;

    modport master (
        output in_valid, in_data, relu_en, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_data, relu_en, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/psum_serial_reducer.sv
// psum_serial_reducer: drains one packed psum vector a column per cycle into a signed sum
module psum_serial_reducer #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int cw      = $clog2(col)
) (
    input  logic                 clk,
    input  logic                 reset,
    psum_serial_reducer_if.slave bus,
    output logic                 busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUM  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;
    localparam int aw = bw_psum + 4;

    logic [1:0]             state_q, state_d;
    logic [aw-1:0]          acc_q, acc_d;
    logic [aw-1:0]          sum_q, sum_d;
    logic [cw-1:0]          cnt_q, cnt_d;
    logic [bw_psum*col-1:0] vec_q, vec_d;
    logic                   flag_q, flag_d;
    logic [bw_psum-1:0]     col0, colk;
    logic                   last;

    assign col0 = bus.in_data[bw_psum-1:0];
    assign colk = vec_q[cnt_q*bw_psum +: bw_psum];
    assign last = cnt_q == cw'(col-1);

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == OUT;
    assign bus.out_sum   = sum_q;
    assign busy          = state_q != IDLE;

    // The presented result is latched when the last column lands, so it stays put under backpressure
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        flag_d  = flag_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                vec_d   = bus.in_data;
                flag_d  = bus.relu_en;
                acc_d   = {{4{col0[bw_psum-1]}}, col0};
                cnt_d   = cw'(1);
                state_d = SUM;
            end
            SUM: begin
                acc_d = acc_q + {{4{colk[bw_psum-1]}}, colk};
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    sum_d   = (flag_q && acc_d[aw-1]) ? '0 : acc_d;
                    state_d = OUT;
                end
            end
            OUT: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            flag_q  <= flag_d;
        end
    end
endmodule
